// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the 5-stage pipeline hazard unit.
//   FORWARD_*    : E-stage forward select encodings (N = register file,
//                  W = writeback result, M = memory-stage result)
//   mdu_state_t  : states of the multi-cycle MDU hold FSM
// ---------------------------------------------------------------------------
package hazard_pkg;

   localparam logic [1:0] FORWARD_N = 2'b00;
   localparam logic [1:0] FORWARD_W = 2'b01;
   localparam logic [1:0] FORWARD_M = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/hazard_fwd_port.sv
// ---------------------------------------------------------------------------
// hazard_fwd_port
// Forwarding decision for a single register read port.
//   raddr_d / raddr_e        : source register of this port in D / E
//   write_reg_m / write_reg_w: destination registers in M / W
//   reg_write_m / reg_write_w: M / W actually write a register
//   mem2reg_m                : M holds a load (data not ready for D compare)
//   forward_e                : E-stage select (FORWARD_M beats FORWARD_W)
//   forward_d                : D-stage branch-compare forward from M
// Register 0 is hard-wired zero and is never forwarded.
// ---------------------------------------------------------------------------
module hazard_fwd_port
   import hazard_pkg::*;
#(
   parameter int REG_SIZE = 5
) (
   input  logic [REG_SIZE-1:0] raddr_d,
   input  logic [REG_SIZE-1:0] raddr_e,
   input  logic [REG_SIZE-1:0] write_reg_m,
   input  logic [REG_SIZE-1:0] write_reg_w,
   input  logic                reg_write_m,
   input  logic                reg_write_w,
   input  logic                mem2reg_m,
   output logic [1:0]          forward_e,
   output logic                forward_d
);

   logic raddr_e_nz_s;
   logic raddr_d_nz_s;

   assign raddr_e_nz_s = (raddr_e != '0);
   assign raddr_d_nz_s = (raddr_d != '0);

   // E-stage forward select; the younger M result takes priority over W
   always_comb begin
      forward_e = FORWARD_N;
      if (raddr_e_nz_s && (raddr_e == write_reg_m) && reg_write_m) begin
         forward_e = FORWARD_M;
      end else if (raddr_e_nz_s && (raddr_e == write_reg_w) && reg_write_w) begin
         forward_e = FORWARD_W;
      end else begin
         forward_e = FORWARD_N;
      end
   end

   // D-stage forward: a load in M has no data yet, so it cannot be forwarded
   always_comb begin
      forward_d = 1'b0;
      if (raddr_d_nz_s && (raddr_d == write_reg_m) && reg_write_m && !mem2reg_m) begin
         forward_d = 1'b1;
      end else begin
         forward_d = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_unit_mc.sv
// ---------------------------------------------------------------------------
// hazard_unit_mc
// Hazard unit for the F/D/E/M/W pipeline.
//   Inputs : raddrD/raddrE (packed per-port source regs), writeReg{E,M,W},
//            regWrite{E,M,W}, mem2reg{E,M}, branchD, pcSrcD, mduStartE
//   Outputs: stallF/stallD/stallE, flushD/flushE/flushM, per-port forwardE
//            (2 bits each) and forwardD, mduBusy, saturating stallCnt and
//            flushCnt performance counters.
// Stall/flush outputs are combinational so they act in the same cycle;
// they are forced low while reset is asserted.
// ---------------------------------------------------------------------------
module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int REG_SIZE   = 5,
   parameter int NUM_RPORTS = 2,
   parameter int MDU_LAT    = 4,
   parameter int CNT_W      = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_RPORTS*REG_SIZE-1:0] raddrD,
   input  logic [NUM_RPORTS*REG_SIZE-1:0] raddrE,
   input  logic [REG_SIZE-1:0]            writeRegE,
   input  logic [REG_SIZE-1:0]            writeRegM,
   input  logic [REG_SIZE-1:0]            writeRegW,
   input  logic                           regWriteE,
   input  logic                           regWriteM,
   input  logic                           regWriteW,
   input  logic                           mem2regE,
   input  logic                           mem2regM,
   input  logic                           branchD,
   input  logic                           pcSrcD,
   input  logic                           mduStartE,
   output logic                           stallF,
   output logic                           stallD,
   output logic                           stallE,
   output logic                           flushD,
   output logic                           flushE,
   output logic                           flushM,
   output logic [NUM_RPORTS*2-1:0]        forwardE,
   output logic [NUM_RPORTS-1:0]          forwardD,
   output logic                           mduBusy,
   output logic [CNT_W-1:0]               stallCnt,
   output logic [CNT_W-1:0]               flushCnt
);

   // Down-counter width; kept at least 1 bit so MDU_LAT of 1 or 2 still elaborates
   localparam int CNT_BITS = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

   logic [NUM_RPORTS-1:0] lw_hit_s;
   logic [NUM_RPORTS-1:0] br_hit_s;
   logic                  lwstall_s;
   logic                  brstall_s;
   logic                  mdu_stall_s;
   logic                  stall_any_s;
   mdu_state_t            state_r;
   mdu_state_t            state_nxt_s;
   logic [CNT_BITS-1:0]   cnt_r;
   logic [CNT_BITS-1:0]   cnt_nxt_s;
   logic [CNT_W-1:0]      stall_cnt_r;
   logic [CNT_W-1:0]      flush_cnt_r;

   for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_port
      logic [REG_SIZE-1:0] rd_s;
      assign rd_s = raddrD[gi*REG_SIZE +: REG_SIZE];

      hazard_fwd_port #(.REG_SIZE(REG_SIZE)) u_fwd (
         .raddr_d     (rd_s),
         .raddr_e     (raddrE[gi*REG_SIZE +: REG_SIZE]),
         .write_reg_m (writeRegM),
         .write_reg_w (writeRegW),
         .reg_write_m (regWriteM),
         .reg_write_w (regWriteW),
         .mem2reg_m   (mem2regM),
         .forward_e   (forwardE[gi*2 +: 2]),
         .forward_d   (forwardD[gi])
      );

      // Per-port operand matches; register 0 never creates a dependency
      assign lw_hit_s[gi] = (rd_s != '0) && (rd_s == writeRegE);
      assign br_hit_s[gi] = (rd_s != '0) &&
                            ((regWriteE && (rd_s == writeRegE)) ||
                             (mem2regM && (rd_s == writeRegM)));
   end

   assign lwstall_s = mem2regE && regWriteE && (|lw_hit_s);
   assign brstall_s = branchD && (|br_hit_s);

   // MDU FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // MDU FSM next state; the start cycle itself stalls, giving MDU_LAT-1 holds
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      mdu_stall_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (mduStartE && (MDU_LAT >= 3)) begin
               state_nxt_s = BUSY;
               cnt_nxt_s   = CNT_BITS'(MDU_LAT - 2);
               mdu_stall_s = 1'b1;
            end else if (mduStartE && (MDU_LAT == 2)) begin
               state_nxt_s = DONE;
               mdu_stall_s = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY: begin
            mdu_stall_s = 1'b1;
            cnt_nxt_s   = cnt_r - CNT_BITS'(1);
            if (cnt_r == CNT_BITS'(1)) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = BUSY;
            end
         end
         // The op is leaving E this cycle; mduStartE still shows it, so ignore it
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   assign stall_any_s = lwstall_s | brstall_s | mdu_stall_s;

   // Pipeline control; an MDU hold freezes D/E, so a pending D hazard waits instead of bubbling
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      if (reset) begin
         stallF = 1'b0;
      end else begin
         stallF = stall_any_s;
         stallD = stall_any_s;
         stallE = mdu_stall_s;
         flushM = mdu_stall_s;
         flushE = (lwstall_s | brstall_s) & ~mdu_stall_s;
         flushD = pcSrcD & ~stall_any_s;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else begin
         if (stallD && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end
         if ((flushD | flushE) && (flush_cnt_r != '1)) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
         end
      end
   end

   assign mduBusy  = (state_r != IDLE);
   assign stallCnt = stall_cnt_r;
   assign flushCnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit_mc
// Scoreboard bench: each scenario pushes the expected outputs for a cycle
// when it drives that cycle's inputs, then pops and compares them mid-cycle.
// Counter expectations come from a small saturating model kept here.
// ---------------------------------------------------------------------------
module tb_hazard_unit_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  raddrD, raddrE;
   logic [4:0]  writeRegE, writeRegM, writeRegW;
   logic        regWriteE, regWriteM, regWriteW;
   logic        mem2regE, mem2regM, branchD, pcSrcD, mduStartE;
   logic        stallF, stallD, stallE, flushD, flushE, flushM, mduBusy;
   logic [3:0]  forwardE;
   logic [1:0]  forwardD;
   logic [3:0]  stallCnt, flushCnt;
   logic [12:0] obs_sig;
   logic [7:0]  obs_cnt;

   typedef struct {
      string       name;
      logic [12:0] sig;
      logic [3:0]  scnt;
      logic [3:0]  fcnt;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] exp_scnt = 4'h0;
   logic [3:0] exp_fcnt = 4'h0;
   int         checks = 0;
   int         passed = 0;

   hazard_unit_mc #(.REG_SIZE(5), .NUM_RPORTS(2), .MDU_LAT(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .raddrD(raddrD), .raddrE(raddrE),
      .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
      .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
      .mem2regE(mem2regE), .mem2regM(mem2regM), .branchD(branchD),
      .pcSrcD(pcSrcD), .mduStartE(mduStartE), .stallF(stallF), .stallD(stallD),
      .stallE(stallE), .flushD(flushD), .flushE(flushE), .flushM(flushM),
      .forwardE(forwardE), .forwardD(forwardD), .mduBusy(mduBusy),
      .stallCnt(stallCnt), .flushCnt(flushCnt)
   );

   always #5 clk = ~clk;

   assign obs_sig = {stallF, stallD, stallE, flushD, flushE, flushM, mduBusy, forwardE, forwardD};
   assign obs_cnt = {stallCnt, flushCnt};

   // stl drives stallF/stallD, mdu drives stallE/flushM
   function automatic logic [12:0] mk(input logic stl, input logic mdu, input logic fd,
                                      input logic fe, input logic busy,
                                      input logic [3:0] fwe, input logic [1:0] fwd);
      return {stl, stl, mdu, fd, fe, mdu, busy, fwe, fwd};
   endfunction

   task automatic push_exp(input string nm, input logic [12:0] s);
      exp_t e;
      e.name = nm; e.sig = s; e.scnt = exp_scnt; e.fcnt = exp_fcnt;
      sb.push_back(e);
      if (s[11] && exp_scnt != 4'hF) exp_scnt = exp_scnt + 4'h1;
      if ((s[9] | s[8]) && exp_fcnt != 4'hF) exp_fcnt = exp_fcnt + 4'h1;
   endtask

   task automatic clear_inputs();
      raddrD = 10'd0; raddrE = 10'd0;
      writeRegE = 5'd0; writeRegM = 5'd0; writeRegW = 5'd0;
      regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
      mem2regE = 1'b0; mem2regM = 1'b0; branchD = 1'b0;
      pcSrcD = 1'b0; mduStartE = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int c = 0; c < 2; c++) begin
         clear_inputs();
         reset = (c == 0);
         // Hazards presented during reset must not reach the outputs
         if (c == 0) begin
            mem2regE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd5; raddrD[4:0] = 5'd5;
            pcSrcD = 1'b1; mduStartE = 1'b1;
         end
         push_exp("reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0));
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (obs_sig !== e.sig) $display("FAIL %s[%0d] outputs got %b want %b", e.name, c, obs_sig, e.sig); else passed++;
         checks++; if (obs_cnt !== {e.scnt, e.fcnt}) $display("FAIL %s[%0d] counters got %h want %h", e.name, c, obs_cnt, {e.scnt, e.fcnt}); else passed++;
         @(posedge clk); #1;
      end
      reset = 1'b0;
   endtask

   task automatic test_forward();
      exp_t e;
      logic [12:0] tab [6];
      tab = '{mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 2'b00),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 2'b01),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 2'b00),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 2'b00),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 2'b00)};
      for (int c = 0; c < 6; c++) begin
         clear_inputs();
         case (c)
            0: begin raddrE[4:0] = 5'd3; writeRegM = 5'd3; regWriteM = 1'b1; writeRegW = 5'd3; regWriteW = 1'b1; end
            1: begin raddrE = {5'd3, 5'd3}; raddrD[4:0] = 5'd3; writeRegM = 5'd3; regWriteM = 1'b1; writeRegW = 5'd3; regWriteW = 1'b1; end
            2: begin raddrE = {5'd3, 5'd3}; raddrD[4:0] = 5'd3; writeRegM = 5'd3; writeRegW = 5'd3; regWriteW = 1'b1; end
            3: begin regWriteM = 1'b1; regWriteW = 1'b1; end
            4: begin raddrE[4:0] = 5'd3; raddrD[9:5] = 5'd3; mem2regM = 1'b1; regWriteM = 1'b1; writeRegM = 5'd3; end
            default: begin raddrE = {5'd4, 5'd3}; writeRegM = 5'd4; regWriteM = 1'b1; writeRegW = 5'd3; regWriteW = 1'b1; end
         endcase
         push_exp("forward", tab[c]);
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (obs_sig !== e.sig) $display("FAIL %s[%0d] outputs got %b want %b", e.name, c, obs_sig, e.sig); else passed++;
         checks++; if (obs_cnt !== {e.scnt, e.fcnt}) $display("FAIL %s[%0d] counters got %h want %h", e.name, c, obs_cnt, {e.scnt, e.fcnt}); else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lwstall();
      exp_t e;
      logic [12:0] tab [4];
      tab = '{mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'h0),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0)};
      for (int c = 0; c < 4; c++) begin
         clear_inputs();
         case (c)
            0: begin mem2regE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd5; raddrD[9:5] = 5'd5; pcSrcD = 1'b1; end
            1: begin mem2regE = 1'b1; regWriteE = 1'b1; end
            2: begin mem2regE = 1'b1; writeRegE = 5'd5; raddrD[9:5] = 5'd5; end
            default: ;
         endcase
         push_exp("lwstall", tab[c]);
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (obs_sig !== e.sig) $display("FAIL %s[%0d] outputs got %b want %b", e.name, c, obs_sig, e.sig); else passed++;
         checks++; if (obs_cnt !== {e.scnt, e.fcnt}) $display("FAIL %s[%0d] counters got %h want %h", e.name, c, obs_cnt, {e.scnt, e.fcnt}); else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      exp_t e;
      logic [12:0] tab [6];
      tab = '{mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'b00),
              mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'b00),
              mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'b00),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'b10),
              mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'b00),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00)};
      for (int c = 0; c < 6; c++) begin
         clear_inputs();
         case (c)
            0: begin branchD = 1'b1; raddrD[4:0] = 5'd7; regWriteE = 1'b1; writeRegE = 5'd7; pcSrcD = 1'b1; end
            1: begin branchD = 1'b1; raddrD[4:0] = 5'd7; pcSrcD = 1'b1; end
            2: begin branchD = 1'b1; raddrD[9:5] = 5'd9; mem2regM = 1'b1; regWriteM = 1'b1; writeRegM = 5'd9; end
            3: begin branchD = 1'b1; raddrD[9:5] = 5'd9; regWriteM = 1'b1; writeRegM = 5'd9; end
            4: begin raddrD[4:0] = 5'd7; regWriteE = 1'b1; writeRegE = 5'd7; pcSrcD = 1'b1; end
            default: begin branchD = 1'b1; regWriteE = 1'b1; end
         endcase
         push_exp("branch", tab[c]);
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (obs_sig !== e.sig) $display("FAIL %s[%0d] outputs got %b want %b", e.name, c, obs_sig, e.sig); else passed++;
         checks++; if (obs_cnt !== {e.scnt, e.fcnt}) $display("FAIL %s[%0d] counters got %h want %h", e.name, c, obs_cnt, {e.scnt, e.fcnt}); else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mdu();
      exp_t e;
      logic [12:0] tab [5];
      tab = '{mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0),
              mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 2'h0),
              mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 2'h0),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'h0),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0)};
      for (int c = 0; c < 5; c++) begin
         clear_inputs();
         mduStartE = (c < 4);
         case (c)
            1: begin mem2regE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd5; raddrD[4:0] = 5'd5; end
            2: pcSrcD = 1'b1;
            default: ;
         endcase
         push_exp("mdu", tab[c]);
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (obs_sig !== e.sig) $display("FAIL %s[%0d] outputs got %b want %b", e.name, c, obs_sig, e.sig); else passed++;
         checks++; if (obs_cnt !== {e.scnt, e.fcnt}) $display("FAIL %s[%0d] counters got %h want %h", e.name, c, obs_cnt, {e.scnt, e.fcnt}); else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [12:0] tab [9];
      tab = '{mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0),
              mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 2'h0),
              mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 2'h0),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'h0),
              mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0),
              mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 2'h0),
              mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 2'h0),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'h0),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0)};
      for (int c = 0; c < 9; c++) begin
         clear_inputs();
         mduStartE = (c < 8);
         push_exp("back_to_back", tab[c]);
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (obs_sig !== e.sig) $display("FAIL %s[%0d] outputs got %b want %b", e.name, c, obs_sig, e.sig); else passed++;
         checks++; if (obs_cnt !== {e.scnt, e.fcnt}) $display("FAIL %s[%0d] counters got %h want %h", e.name, c, obs_cnt, {e.scnt, e.fcnt}); else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_busy();
      exp_t e;
      logic [12:0] tab [3];
      tab = '{mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'h0),
              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0)};
      for (int c = 0; c < 3; c++) begin
         clear_inputs();
         reset = (c == 1);
         mduStartE = (c < 2);
         if (c == 1) pcSrcD = 1'b1;
         push_exp("reset_busy", tab[c]);
         if (c == 1) begin
            exp_scnt = 4'h0;
            exp_fcnt = 4'h0;
         end
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (obs_sig !== e.sig) $display("FAIL %s[%0d] outputs got %b want %b", e.name, c, obs_sig, e.sig); else passed++;
         checks++; if (obs_cnt !== {e.scnt, e.fcnt}) $display("FAIL %s[%0d] counters got %h want %h", e.name, c, obs_cnt, {e.scnt, e.fcnt}); else passed++;
         @(posedge clk); #1;
      end
      reset = 1'b0;
   endtask

   task automatic test_saturate();
      exp_t e;
      // 2^4+3 stalled cycles, then one quiet cycle to see the held value
      for (int c = 0; c < 20; c++) begin
         clear_inputs();
         if (c < 19) begin
            mem2regE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd5; raddrD[4:0] = 5'd5;
            push_exp("saturate", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'h0));
         end else begin
            push_exp("saturate", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0));
         end
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (obs_sig !== e.sig) $display("FAIL %s[%0d] outputs got %b want %b", e.name, c, obs_sig, e.sig); else passed++;
         checks++; if (obs_cnt !== {e.scnt, e.fcnt}) $display("FAIL %s[%0d] counters got %h want %h", e.name, c, obs_cnt, {e.scnt, e.fcnt}); else passed++;
         @(posedge clk); #1;
      end
      checks++;
      if (exp_scnt !== 4'hF || stallCnt !== 4'hF) $display("FAIL saturate_final stallCnt got %h want %h", stallCnt, 4'hF); else passed++;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_forward();
      test_lwstall();
      test_branch();
      test_mdu();
      test_back_to_back();
      test_reset_busy();
      test_saturate();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
